// File: rtl/sum_accumulator.sv
// Accumulates a fixed number of adder results into a saturating total and
// hands the finished total downstream over a valid/ready handshake.
module sum_accumulator #(
    parameter int DATA_W    = 5,
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_total,
    output logic [3:0]        out_count,
    output logic              overflow,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] N_LAST = 4'(N_SAMPLES);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [ACC_W:0]   sum_w;
    logic [3:0]       count_inc;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and in_ready drops combinationally on clear.
    assign in_ready  = (state_q != DONE) && !clear;
    assign accept    = in_valid && in_ready;
    assign sum_w     = {1'b0, acc_q} + (ACC_W+1)'(in_sum);
    assign count_inc = count_q + 4'd1;

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign out_total = acc_q;
    assign out_count = count_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = ACC_W'(in_sum);
                        count_d = 4'd1;
                        state_d = (N_LAST == 4'd1) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        count_d = count_inc;
                        // Carry out of the accumulator ends the run early, pinned at full scale.
                        if (sum_w[ACC_W]) begin
                            acc_d   = '1;
                            ovf_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            acc_d = sum_w[ACC_W-1:0];
                            if (count_inc == N_LAST) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three instances (N=4, N=15, N=1) share stimulus;
// each run targets one instance and the others are cleared before every run.
module tb_sum_accumulator;

    logic       clock = 1'b0;
    logic       resetn, clear, in_valid, out_ready;
    logic [4:0] in_sum;

    logic [2:0] ir, ov, of, bz;
    logic [7:0] tot [3];
    logic [3:0] cnt [3];
    logic [1:0] st  [3];

    always #5 clock = ~clock;

    sum_accumulator #(.DATA_W(5), .ACC_W(8), .N_SAMPLES(4)) dut4 (
        .clock(clock), .resetn(resetn), .clear(clear), .in_valid(in_valid),
        .in_ready(ir[0]), .in_sum(in_sum), .out_valid(ov[0]), .out_ready(out_ready),
        .out_total(tot[0]), .out_count(cnt[0]), .overflow(of[0]), .busy(bz[0]),
        .dbg_state(st[0]));

    sum_accumulator #(.DATA_W(5), .ACC_W(8), .N_SAMPLES(15)) dut15 (
        .clock(clock), .resetn(resetn), .clear(clear), .in_valid(in_valid),
        .in_ready(ir[1]), .in_sum(in_sum), .out_valid(ov[1]), .out_ready(out_ready),
        .out_total(tot[1]), .out_count(cnt[1]), .overflow(of[1]), .busy(bz[1]),
        .dbg_state(st[1]));

    sum_accumulator #(.DATA_W(5), .ACC_W(8), .N_SAMPLES(1)) dut1 (
        .clock(clock), .resetn(resetn), .clear(clear), .in_valid(in_valid),
        .in_ready(ir[2]), .in_sum(in_sum), .out_valid(ov[2]), .out_ready(out_ready),
        .out_total(tot[2]), .out_count(cnt[2]), .overflow(of[2]), .busy(bz[2]),
        .dbg_state(st[2]));

    typedef struct {
        int         sel;
        int         n;
        logic [4:0] s [15];
        logic [7:0] exp_total;
        logic [3:0] exp_count;
        logic       exp_ovf;
        bit         gapped;
        int         hold;
    } vec_t;

    vec_t        tbl [5];
    logic [12:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic clear_all();
        clear     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          sel;
        int          accepted;
        logic [12:0] e;
        sel      = v.sel;
        accepted = 0;
        clear_all();
        exp_q.push_back({v.exp_ovf, v.exp_count, v.exp_total});
        // Inputs change 1 time unit after each edge; DUT is observed on the falling edge.
        for (int i = 0; i < v.n; i++) begin
            in_valid = 1'b1;
            in_sum   = v.s[i];
            mid();
            chk("count_mid", cnt[sel], accepted);
            chk("busy_mid", bz[sel], accepted > 0);
            if (!ir[sel]) break;
            tick();
            accepted++;
            if (v.gapped && i < v.n - 1) begin
                in_valid = 1'b0;
                in_sum   = 5'($urandom_range(0, 31));
                mid();
                chk("gap_count", cnt[sel], accepted);
                tick();
            end
        end
        if (accepted == v.n) begin
            in_valid = 1'b1;
            in_sum   = 5'($urandom_range(0, 31));
            mid();
        end
        chk("latency_out_valid", ov[sel], 1);
        chk("done_in_ready", ir[sel], 0);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            in_valid = 1'b1;
            in_sum   = 5'($urandom_range(0, 31));
            mid();
            chk("hold_in_ready", ir[sel], 0);
            chk("hold_out_valid", ov[sel], 1);
            chk("hold_total", tot[sel], v.exp_total);
            chk("hold_count", cnt[sel], v.exp_count);
            chk("hold_ovf", of[sel], v.exp_ovf);
        end
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("sb_total", tot[sel], e[7:0]);
            chk("sb_count", cnt[sel], e[11:8]);
            chk("sb_ovf", of[sel], e[12]);
        end
        // Output handshake with in_valid still high: no sample may slip in on this edge.
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = 5'd7;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        mid();
        chk("post_out_valid", ov[sel], 0);
        chk("post_total", tot[sel], 0);
        chk("post_count", cnt[sel], 0);
        chk("post_busy", bz[sel], 0);
        chk("post_in_ready", ir[sel], 1);
        tick();
    endtask

    task automatic feed_two();
        in_valid = 1'b1;
        in_sum   = 5'd3;
        tick();
        in_sum = 5'd5;
        tick();
        in_valid = 1'b0;
        mid();
        chk("pre_abort_total", tot[0], 8);
        chk("pre_abort_count", cnt[0], 2);
    endtask

    task automatic random_run(input int sel);
        vec_t v;
        int   acc;
        int   c;
        bit   o;
        v.sel = sel;
        v.n   = (sel == 0) ? 4 : 15;
        v.gapped = 1'b0;
        v.hold   = int'($urandom_range(0, 3));
        acc = 0;
        c   = 0;
        o   = 1'b0;
        for (int i = 0; i < 15; i++) v.s[i] = 5'($urandom_range(0, 31));
        for (int i = 0; i < v.n; i++) begin
            c++;
            acc += int'(v.s[i]);
            if (acc > 255) begin
                acc = 255;
                o   = 1'b1;
                break;
            end
        end
        v.exp_total = 8'(acc);
        v.exp_count = 4'(c);
        v.exp_ovf   = o;
        run_vec(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn    = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sum    = '0;

        tbl[0] = '{sel: 0, n: 4, s: '{3, 5, 7, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   exp_total: 8'd24, exp_count: 4'd4, exp_ovf: 1'b0, gapped: 1'b0, hold: 2};
        tbl[1] = '{sel: 0, n: 4, s: '{31, 31, 31, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   exp_total: 8'd124, exp_count: 4'd4, exp_ovf: 1'b0, gapped: 1'b0, hold: 10};
        tbl[2] = '{sel: 1, n: 15, s: '{31, 31, 31, 31, 31, 31, 31, 31, 31, 31, 31, 31, 31, 31, 31},
                   exp_total: 8'd255, exp_count: 4'd9, exp_ovf: 1'b1, gapped: 1'b0, hold: 3};
        tbl[3] = '{sel: 0, n: 4, s: '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   exp_total: 8'd10, exp_count: 4'd4, exp_ovf: 1'b0, gapped: 1'b1, hold: 1};
        tbl[4] = '{sel: 2, n: 1, s: '{17, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   exp_total: 8'd17, exp_count: 4'd1, exp_ovf: 1'b0, gapped: 1'b0, hold: 1};

        #3;
        chk("rst_out_valid", ov[0], 0);
        chk("rst_total", tot[0], 0);
        chk("rst_count", cnt[0], 0);
        chk("rst_ovf", of[0], 0);
        chk("rst_busy", bz[0], 0);
        chk("rst_in_ready", ir[0], 1);
        chk("rst_state", st[0], 0);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;

        for (int v = 0; v < 5; v++) run_vec(tbl[v]);

        // Clear mid-run with a sample offered in the same cycle.
        clear_all();
        feed_two();
        tick();
        clear    = 1'b1;
        in_valid = 1'b1;
        in_sum   = 5'd9;
        mid();
        chk("clear_in_ready", ir[0], 0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        mid();
        chk("clear_total", tot[0], 0);
        chk("clear_count", cnt[0], 0);
        chk("clear_busy", bz[0], 0);
        chk("clear_state", st[0], 0);
        tick();

        // Asynchronous reset between edges mid-run.
        feed_two();
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_total", tot[0], 0);
        chk("areset_count", cnt[0], 0);
        chk("areset_out_valid", ov[0], 0);
        chk("areset_busy", bz[0], 0);
        chk("areset_in_ready", ir[0], 1);
        #1;
        resetn = 1'b1;
        tick();

        run_vec(tbl[0]);

        for (int r = 0; r < 4; r++) random_run(0);
        for (int r = 0; r < 3; r++) random_run(1);

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the 4-bit ripple-carry adder stage. Accepts each 5-bit adder result ({cout, s[3:0]}) over a valid/ready handshake and sums a fixed number of results into a wider running total. Presents the finished total, the sample count and an overflow flag to the display/output stage over a second valid/ready handshake. Gives the adder datapath a clocked accumulate-and-report stage in the lab design.

## Interface
- DATA_W, 5, input sample width: adder carry-out as MSB plus 4 sum bits
- ACC_W, 8, accumulator and total width
- N_SAMPLES, 4, samples per accumulation run; legal range 1..15

- clock  in  1  single system clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort/clear; highest priority after resetn
- in_valid  in  1  upstream sample valid
- in_ready  out  1  block can accept a sample; = (state != DONE) && !clear
- in_sum  in  DATA_W  adder result {cout, s[3:0]}, unsigned 0..31
- out_valid  out  1  total is valid; high exactly in DONE
- out_ready  in  1  downstream accepts total
- out_total  out  ACC_W  accumulated total, registered
- out_count  out  4  samples absorbed in the current or finished run, registered
- overflow  out  1  run ended by saturation, registered
- busy  out  1  high in RUN or DONE

## Operation
- **States**: IDLE, RUN, DONE. Reset and clear both force IDLE with acc=0, count=0, overflow=0.
- **Accept**: a sample is accepted on a rising edge where in_valid && in_ready.
- **IDLE**
  - Accept: acc = zero-extended in_sum, count = 1.
  - Next state is DONE if N_SAMPLES == 1, else RUN.
  - No accept: hold.
- **RUN**
  - Accept: form the ACC_W+1-bit sum acc + in_sum, and set count = count + 1.
  - If bit ACC_W of that sum is 1: acc saturates to all ones, overflow = 1, next state DONE, regardless of count.
  - Else: acc = sum[ACC_W-1:0]. Next state is DONE when the new count == N_SAMPLES, else RUN.
- **DONE**
  - in_ready = 0. out_valid = 1. out_total, out_count and overflow are held stable.
  - On out_valid && out_ready: next state IDLE, and acc, count and overflow are cleared to 0.
- **Arithmetic**: all unsigned. The total is never allowed to wrap; it saturates instead.
- **Output mapping**: out_total = acc and out_count = count in every state. They are visible mid-run.
- **clear**
  - Asserted in any state: the next edge goes to IDLE with all registers zeroed.
  - A sample presented in the same cycle is not accepted, because in_ready is low.
  - A pending output in DONE is discarded, even if out_ready is high.
- **resetn low (any time, including mid-run)**: immediately forces IDLE, acc=0, count=0, overflow=0, out_valid=0. in_ready stays 1 while clear is low.

## Timing
- **Reset values**: out_valid=0, out_total=0, out_count=0, overflow=0, busy=0, in_ready=1 (when clear=0).
- **Throughput**: one sample per cycle in IDLE and RUN; no bubbles between samples.
- **Latency to result**: the edge that accepts the final sample, or the overflowing sample, registers the result. out_valid is high in the following cycle.
- **DONE to next run**: the output handshake completes at edge k. in_ready is high from cycle k+1, so the first new sample can be accepted at edge k+1.
- **No bypass**: a sample cannot be accepted in the same cycle the output handshake completes.
- **Held output**: out_valid stays high indefinitely while out_ready is low. Outputs must not change during this time.
- **Combinational paths**: only in_ready depends combinationally on an input (clear). out_valid and busy are decoded from state registers.

## Test plan
- **Basic run**: N=4, samples 3, 5, 7, 9 on consecutive cycles.
  - out_valid rises the cycle after the 4th accept with out_total=24, out_count=4, overflow=0.
  - out_ready=1 returns the block to IDLE; in_ready=1 on the next cycle.
- **Max input**: N=4, four samples of 31 → out_total=124, overflow=0.
- **Backpressure**: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with varying in_sum.
  - in_ready=0 throughout.
  - out_total, out_count and overflow are unchanged.
  - No sample is absorbed.
- **Overflow**: N=15, sample 31 every cycle.
  - After the 9th accept: out_total=255, out_count=9, overflow=1, out_valid=1.
  - The 10th sample is not accepted.
- **Gapped input / N=1**
  - N=4 with in_valid toggling every other cycle, samples 1, 2, 3, 4 → out_total=10 after 4 accepts; count advances only on handshakes.
  - Separately, N=1 with sample 17 → DONE the next cycle with out_total=17, out_count=1.
- **Clear and reset mid-run**
  - After 2 samples (acc=8), pulse clear with in_valid=1 → next cycle IDLE, out_total=0, out_count=0, sample dropped.
  - Repeat with resetn pulsed low asynchronously between edges → outputs zero immediately.
  - A subsequent clean 4-sample run produces the correct total.
